// File: rtl/forward_hazard_unit.sv
// -----------------------------------------------------------------------------
// forward_hazard_unit
//
// Purpose: hazard detection, stall/flush control and operand-forward selection
// for a classic five-stage pipeline (IF/ID/EX/MEM/WB) with caches.
//
// Configuration macro: FORWARD_HAZARD_FORWARD_EN
//   defined   -> EX operands are forwarded from EX/MEM and MEM/WB; only a
//                load-use dependency costs a bubble.
//   undefined -> no forwarding (fwdA/fwdB always select the register file);
//                any RAW dependency on EX or MEM stalls ID. WB needs no stall
//                because the register file writes through to its read port.
//
// Ports:
//   CLK, RST                          clock, synchronous active-high reset
//   ifid_rs, ifid_rt                  source registers of the ID instruction
//   idex_rs, idex_rt                  source registers of the EX instruction
//   idex_wsel/regwen/dren             EX destination, write enable, load flag
//   exmem_wsel/regwen/dmemreq         MEM destination, write enable, dmem access
//   memwb_wsel/regwen/halt            WB destination, write enable, halt retiring
//   ihit, dhit                        instruction / data cache hit
//   pcsrc                             next-PC select from EX (0 = PC+4)
//   fwdA, fwdB                        operand selects (0 MEM/WB, 1 EX/MEM, 2 RF)
//   pc_en .. memwb_en                 stage advance enables
//   ifid_flush, idex_flush,
//   memwb_flush                       load a bubble into that latch
//   halted                            halt indication
//   stall_cnt                         saturating count of stalled (pc_en=0) cycles
// -----------------------------------------------------------------------------
module forward_hazard_unit (
    input  logic        CLK,
    input  logic        RST,
    input  logic [4:0]  ifid_rs,
    input  logic [4:0]  ifid_rt,
    input  logic [4:0]  idex_rs,
    input  logic [4:0]  idex_rt,
    input  logic [4:0]  idex_wsel,
    input  logic        idex_regwen,
    input  logic        idex_dren,
    input  logic [4:0]  exmem_wsel,
    input  logic        exmem_regwen,
    input  logic        exmem_dmemreq,
    input  logic [4:0]  memwb_wsel,
    input  logic        memwb_regwen,
    input  logic        memwb_halt,
    input  logic        ihit,
    input  logic        dhit,
    input  logic [1:0]  pcsrc,
    output logic [1:0]  fwdA,
    output logic [1:0]  fwdB,
    output logic        pc_en,
    output logic        ifid_en,
    output logic        idex_en,
    output logic        exmem_en,
    output logic        memwb_en,
    output logic        ifid_flush,
    output logic        idex_flush,
    output logic        memwb_flush,
    output logic        halted,
    output logic [15:0] stall_cnt
);

    localparam logic [1:0] FWD_OUT4 = 2'd0;   // MEM/WB value
    localparam logic [1:0] FWD_OUT3 = 2'd1;   // EX/MEM value
    localparam logic [1:0] FWD_RDAT = 2'd2;   // register file

    localparam logic [1:0] PC_ADD4  = 2'd0;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DWAIT = 2'd1,
        ST_HALT  = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [15:0] r_stall_cnt;

    logic        w_dmiss;
    logic        w_halt;
    logic        w_data_hazard;
    logic        w_count;
    logic [1:0]  w_fwd [2];

    assign w_dmiss = exmem_dmemreq & ~dhit;

    // Halt takes effect in the cycle memwb_halt is seen, not one cycle late,
    // so nothing behind the halting instruction slips through. While RST is
    // high the outputs behave as in RUN.
    assign w_halt = ~RST & ((r_state == ST_HALT) | memwb_halt);

    // ------------------------------------------------------------------
    // Data-dependency detection and operand forwarding
    // ------------------------------------------------------------------
`ifdef FORWARD_HAZARD_FORWARD_EN
    // With forwarding only a load in EX cannot supply its value in time.
    assign w_data_hazard = idex_dren & idex_regwen & (idex_wsel != 5'd0) &
                           ((idex_wsel == ifid_rs) | (idex_wsel == ifid_rt));

    // Operand 0 is rs (fwdA), operand 1 is rt (fwdB). EX/MEM holds the
    // younger result, so it wins over MEM/WB.
    for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
        logic [4:0] w_src;
        assign w_src = (gi == 0) ? idex_rs : idex_rt;

        always_comb begin
            w_fwd[gi] = FWD_RDAT;
            if (exmem_regwen && (exmem_wsel != 5'd0) && (exmem_wsel == w_src)) begin
                w_fwd[gi] = FWD_OUT3;
            end else if (memwb_regwen && (memwb_wsel != 5'd0) && (memwb_wsel == w_src)) begin
                w_fwd[gi] = FWD_OUT4;
            end
        end
    end
`else
    // Without forwarding, ID waits until the producer has left MEM.
    logic [1:0] w_raw_hit;

    for (genvar gi = 0; gi < 2; gi++) begin : g_raw
        logic [4:0] w_dst;
        logic       w_wen;
        assign w_dst = (gi == 0) ? idex_wsel   : exmem_wsel;
        assign w_wen = (gi == 0) ? idex_regwen : exmem_regwen;
        assign w_raw_hit[gi] = w_wen & (w_dst != 5'd0) &
                               ((w_dst == ifid_rs) | (w_dst == ifid_rt));
    end

    assign w_data_hazard = |w_raw_hit;

    for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
        assign w_fwd[gi] = FWD_RDAT;
    end

    logic w_unused;
    assign w_unused = &{1'b0, idex_rs, idex_rt, idex_dren, memwb_wsel, memwb_regwen};
`endif

    assign fwdA = w_fwd[0];
    assign fwdB = w_fwd[1];

    // ------------------------------------------------------------------
    // State register and stall counter
    // ------------------------------------------------------------------
    assign w_count = ~w_halt & ~pc_en & (r_stall_cnt != 16'hFFFF);

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state     <= ST_RUN;
            r_stall_cnt <= 16'd0;
        end else begin
            r_state <= w_state_next;
            if (w_count) begin
                r_stall_cnt <= r_stall_cnt + 16'd1;
            end
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign halted    = w_halt;

    // ------------------------------------------------------------------
    // Next state and stage control, highest priority first
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        pc_en        = 1'b1;
        ifid_en      = 1'b1;
        idex_en      = 1'b1;
        exmem_en     = 1'b1;
        memwb_en     = 1'b1;
        ifid_flush   = 1'b0;
        idex_flush   = 1'b0;
        memwb_flush  = 1'b0;

        case (r_state)
            ST_RUN: begin
                if (memwb_halt)   w_state_next = ST_HALT;
                else if (w_dmiss) w_state_next = ST_DWAIT;
            end
            ST_DWAIT: begin
                if (memwb_halt)   w_state_next = ST_HALT;
                else if (dhit)    w_state_next = ST_RUN;
            end
            ST_HALT: begin
                w_state_next = ST_HALT;
            end
            default: begin
                w_state_next = ST_RUN;
            end
        endcase

        if (w_halt) begin
            pc_en    = 1'b0;
            ifid_en  = 1'b0;
            idex_en  = 1'b0;
            exmem_en = 1'b0;
            memwb_en = 1'b0;
        end else if (w_dmiss) begin
            // Freeze everything up to MEM; WB drains and receives a bubble
            // so the retiring instruction is not written twice.
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_en     = 1'b0;
            exmem_en    = 1'b0;
            memwb_flush = 1'b1;
        end else if (pcsrc != PC_ADD4) begin
            // Squash the two wrong-path instructions behind the transfer.
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else if (w_data_hazard) begin
            // Hold PC and IF/ID; a bubble enters EX. The condition clears by
            // itself once the producer has advanced.
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
        end else if (!ihit) begin
            pc_en      = 1'b0;
            ifid_flush = 1'b1;
        end
    end

endmodule
